set_bit_scanner: RTL and testbench
==================================

# set_bit_scanner

Sequential successor to the combinational MSB-position priority encoder. It accepts an IN_WIDTH-bit word over a valid/ready handshake and emits the index of every set bit, one per output beat, in MSB-first or LSB-first order. Each beat also carries the word's total set-bit count, a last-beat flag and a zero-word flag. It sits between a bitmask producer (request/flag vectors) and any consumer that services set bits one at a time.

## Interface
- IN_WIDTH, 8: input word width; must be >= 2.
- LSB_FIRST, 0: scan order; 0 = highest set bit first, 1 = lowest set bit first.
- OUT_WIDTH (localparam): $clog2(IN_WIDTH).
- CNT_WIDTH (localparam): $clog2(IN_WIDTH+1).

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word.
- in_data  input  IN_WIDTH  word to scan.
- out_valid  output  1  out_* fields valid.
- out_ready  input  1  consumer accepts current beat.
- out_pos  output  OUT_WIDTH  index of current set bit.
- out_last  output  1  final beat of current word.
- out_zero  output  1  captured word was all zeros.
- out_count  output  CNT_WIDTH  popcount of captured word; constant for all beats of a word.

## Operation
- Two states: IDLE, SCAN.
- IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, the block loads in_data into the work register, latches popcount(in_data) into out_count and sets out_zero = (in_data==0). Next state is SCAN.
- SCAN: in_ready=0, out_valid=1. While in SCAN, in_valid is ignored.
  - out_pos = MSB index of work (LSB index if LSB_FIRST=1).
  - out_last = 1 when work has at most one bit set.
- Beat handshake (out_valid&&out_ready):
  - Clears bit out_pos in work.
  - If out_last, next state is IDLE; otherwise the block stays in SCAN.
- Zero word produces exactly one beat: out_zero=1, out_pos=0, out_last=1, out_count=0.
- Stall (out_valid && !out_ready): all out_* fields hold stable and work is unchanged.
- out_pos, out_last and out_zero are combinational from the work register and state. They never depend combinationally on in_* or out_ready.
- in_ready is a pure function of state.

## Timing
- Reset (rst high at a clock edge): state=IDLE, work=0, out_count=0, out_zero=0. Result: out_valid=0, in_ready=1, out_pos=0, out_last=1.
- Reset mid-SCAN: the block drops the word immediately. out_valid=0 from the cycle after the reset edge, and no further beats from that word are produced.
- Latency: word accepted at edge N, first beat valid in cycle N+1.
- Throughput: one beat per cycle while out_ready=1.
  - Non-zero word occupies popcount(word) SCAN cycles.
  - Zero word occupies 1 SCAN cycle.
  - One IDLE cycle follows each word (in_ready returns high the cycle after the last beat handshake).
- If in_valid and the last-beat handshake occur in the same cycle, the new word is not accepted that cycle. It is accepted in the following IDLE cycle.
- Bits of work are only ever cleared; no wrap-around.
- out_count saturates naturally at IN_WIDTH, which fits in CNT_WIDTH.

## Structure
- Package set_bit_scan_pkg provides:
  - function msb_index(word) and function lsb_index(word): return OUT_WIDTH index, 0 for zero input.
  - function popcount(word).
  - function onehot_or_zero(word).
  - typedef enum logic {IDLE, SCAN} scan_state_t.
- Functions are width-generic via a package-level MAX_WIDTH=64 with zero-extended inputs. The top level truncates results.
- One combinational sub-module, prio_enc: parameter IN_WIDTH, LSB_FIRST; ports in, pos. It is instantiated once on the work register.
- Top level holds only the FSM, the work register, the out_count/out_zero registers and the handshake logic.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, in_ready=1 throughout. No word is accepted until after rst falls.
- IN_WIDTH=8, LSB_FIRST=0, in_data=8'b1010_0100, out_ready=1:
  - Beats out_pos=7,5,2; out_last only on pos 2; out_count=3 on all beats.
  - in_ready is back to 1 one cycle after the last beat.
- Zero word 8'h00 -> single beat out_zero=1, out_pos=0, out_last=1, out_count=0, then IDLE.
- Backpressure: 8'hFF with out_ready pseudo-random (~50%):
  - out_pos sequence 7..0, held stable during every stall; out_count=8.
  - in_valid pulses during SCAN are not accepted.
- LSB_FIRST=1, 8'b1010_0100 -> beats 2,5,7. Also run IN_WIDTH=13: in_data=13'h1001 -> beats 0,12, out_count=2.
- Reset after first beat of 8'hF0 (pos 7 taken) -> out_valid=0 next cycle, no pos 6. Then send 8'h01 -> single beat pos 0, out_last=1, out_count=1.

Source files
------------

// File: rtl/set_bit_scan_pkg.sv
// set_bit_scan_pkg
// Shared types and width-generic bit-scan helpers for set_bit_scanner.
// All helpers take a MAX_WIDTH-bit word. Callers zero-extend narrower words
// and truncate the results to their own index/count widths.
//   msb_index(word)      : index of highest set bit, 0 when word is zero
//   lsb_index(word)      : index of lowest set bit, 0 when word is zero
//   popcount(word)       : number of set bits
//   onehot_or_zero(word) : 1 when at most one bit is set
package set_bit_scan_pkg;

    localparam int MAX_WIDTH = 64;
    localparam int MAX_IDX_W = $clog2(MAX_WIDTH);
    localparam int MAX_CNT_W = $clog2(MAX_WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // Ascending scan: the last set bit seen is the highest one.
    function automatic logic [MAX_IDX_W-1:0] msb_index(input logic [MAX_WIDTH-1:0] word);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (word[i]) begin
                idx = MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Descending scan: the last set bit seen is the lowest one.
    function automatic logic [MAX_IDX_W-1:0] lsb_index(input logic [MAX_WIDTH-1:0] word);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_WIDTH - 1; i >= 0; i--) begin
            if (word[i]) begin
                idx = MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [MAX_CNT_W-1:0] popcount(input logic [MAX_WIDTH-1:0] word);
        logic [MAX_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            cnt = cnt + MAX_CNT_W'(word[i]);
        end
        return cnt;
    endfunction

    // Clearing the lowest set bit leaves zero exactly when at most one bit was set.
    function automatic logic onehot_or_zero(input logic [MAX_WIDTH-1:0] word);
        return (word & (word - MAX_WIDTH'(1))) == '0;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// prio_enc
// Combinational priority encoder used on the scanner's work register.
// Ports:
//   in  [IN_WIDTH]  : word to encode
//   pos [OUT_WIDTH] : index of highest set bit (LSB_FIRST=0) or lowest set
//                     bit (LSB_FIRST=1); 0 when in is zero
// IN_WIDTH must lie between 2 and set_bit_scan_pkg::MAX_WIDTH.
module prio_enc
    import set_bit_scan_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int LSB_FIRST = 0,
    localparam int OUT_WIDTH = $clog2(IN_WIDTH)
) (
    input  logic [IN_WIDTH-1:0]  in,
    output logic [OUT_WIDTH-1:0] pos
);

    logic [MAX_WIDTH-1:0] in_ext;

    assign in_ext = MAX_WIDTH'(in);

    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign pos = OUT_WIDTH'(lsb_index(in_ext));
        end else begin : g_msb_first
            assign pos = OUT_WIDTH'(msb_index(in_ext));
        end
    endgenerate

endmodule

// File: rtl/set_bit_scanner.sv
// set_bit_scanner
// Accepts a word over valid/ready and emits the index of each set bit, one
// beat per cycle, MSB-first (LSB_FIRST=0) or LSB-first (LSB_FIRST=1).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_ready is high only in IDLE
//   in_data  [IN_WIDTH] : word to scan
//   out_valid/out_ready : output beat handshake; out_valid is high only in SCAN
//   out_pos  [OUT_WIDTH]: index of current set bit
//   out_last            : final beat of current word
//   out_zero            : captured word was all zeros (single beat, pos 0)
//   out_count[CNT_WIDTH]: popcount of captured word, constant across its beats
module set_bit_scanner
    import set_bit_scan_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int LSB_FIRST = 0,
    localparam int OUT_WIDTH = $clog2(IN_WIDTH),
    localparam int CNT_WIDTH = $clog2(IN_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_pos,
    output logic                 out_last,
    output logic                 out_zero,
    output logic [CNT_WIDTH-1:0] out_count
);

    scan_state_t          state_reg, state_next;
    logic [IN_WIDTH-1:0]  work_reg, work_next;
    logic [CNT_WIDTH-1:0] count_reg, count_next;
    logic                 zero_reg, zero_next;
    logic [IN_WIDTH-1:0]  clear_mask;

    prio_enc #(
        .IN_WIDTH  (IN_WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_prio_enc (
        .in  (work_reg),
        .pos (out_pos)
    );

    // One-hot mask of the bit currently being presented. For a zero word
    // this selects bit 0, and clearing an already-clear bit is harmless.
    genvar gi;
    generate
        for (gi = 0; gi < IN_WIDTH; gi++) begin : g_clear_mask
            assign clear_mask[gi] = (out_pos == OUT_WIDTH'(gi));
        end
    endgenerate

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == SCAN);
    // Work is zero in IDLE and after reset, so out_last reads 1 there.
    assign out_last  = onehot_or_zero(MAX_WIDTH'(work_reg));
    assign out_zero  = zero_reg;
    assign out_count = count_reg;

    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        count_next = count_reg;
        zero_next  = zero_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    work_next  = in_data;
                    count_next = CNT_WIDTH'(popcount(MAX_WIDTH'(in_data)));
                    zero_next  = (in_data == '0);
                    state_next = SCAN;
                end
            end
            SCAN: begin
                // in_valid is ignored here, including on the last beat, so a
                // waiting word is taken in the following IDLE cycle.
                if (out_ready) begin
                    work_next = work_reg & ~clear_mask;
                    if (out_last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            count_reg <= '0;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            count_reg <= count_next;
            zero_reg  <= zero_next;
        end
    end

endmodule

// File: tb/tb_set_bit_scanner.sv
// tb_set_bit_scanner
// Directed bench for set_bit_scanner: three instances (8-bit MSB-first,
// 8-bit LSB-first, 13-bit LSB-first) driven from one linear initial block.
module tb_set_bit_scanner;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Instance A: IN_WIDTH=8, MSB-first
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data;
    logic [2:0] a_out_pos;
    logic       a_out_last, a_out_zero;
    logic [3:0] a_out_count;

    // Instance B: IN_WIDTH=8, LSB-first
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0] b_in_data;
    logic [2:0] b_out_pos;
    logic       b_out_last, b_out_zero;
    logic [3:0] b_out_count;

    // Instance C: IN_WIDTH=13, LSB-first
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [12:0] c_in_data;
    logic [3:0]  c_out_pos;
    logic        c_out_last, c_out_zero;
    logic [3:0]  c_out_count;

    set_bit_scanner #(.IN_WIDTH(8), .LSB_FIRST(0)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pos(a_out_pos),
        .out_last(a_out_last), .out_zero(a_out_zero), .out_count(a_out_count)
    );

    set_bit_scanner #(.IN_WIDTH(8), .LSB_FIRST(1)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pos(b_out_pos),
        .out_last(b_out_last), .out_zero(b_out_zero), .out_count(b_out_count)
    );

    set_bit_scanner #(.IN_WIDTH(13), .LSB_FIRST(1)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_pos(c_out_pos),
        .out_last(c_out_last), .out_zero(c_out_zero), .out_count(c_out_count)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check one presented beat on instance A.
    task automatic a_beat(input string tag, input int pos, input logic last,
                          input int cnt, input logic zero);
        $display("A beat %s: pos=%0d last=%0d count=%0d zero=%0d ready=%0d",
                 tag, a_out_pos, a_out_last, a_out_count, a_out_zero, a_out_ready);
        check({tag, " out_valid"}, 32'(a_out_valid), 32'd1);
        check({tag, " in_ready"},  32'(a_in_ready),  32'd0);
        check({tag, " out_pos"},   32'(a_out_pos),   32'(pos));
        check({tag, " out_last"},  32'(a_out_last),  32'(last));
        check({tag, " out_count"}, 32'(a_out_count), 32'(cnt));
        check({tag, " out_zero"},  32'(a_out_zero),  32'(zero));
    endtask

    // Present a word on A for one cycle while it is IDLE.
    task automatic a_send(input logic [7:0] w);
        check("a_send in_ready", 32'(a_in_ready), 32'd1);
        a_in_valid = 1'b1;
        a_in_data  = w;
        step();
        a_in_valid = 1'b0;
        $display("A word 0x%02h accepted", w);
    endtask

    task automatic a_idle(input string tag);
        check({tag, " out_valid"}, 32'(a_out_valid), 32'd0);
        check({tag, " in_ready"},  32'(a_in_ready),  32'd1);
    endtask

    int b_exp [3] = '{2, 5, 7};
    int c_exp [2] = '{0, 12};

    initial begin
        int idx;
        int cyc;

        rst = 1'b1;
        a_in_valid = 1'b1; a_in_data = 8'hAA; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0;    b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_data = '0;    c_out_ready = 1'b1;

        // Reset held two cycles with in_valid high: nothing may be captured.
        step();
        a_idle("rst1");
        step();
        a_idle("rst2");
        check("rst out_pos",   32'(a_out_pos),   32'd0);
        check("rst out_last",  32'(a_out_last),  32'd1);
        check("rst out_count", 32'(a_out_count), 32'd0);
        check("rst out_zero",  32'(a_out_zero),  32'd0);
        rst = 1'b0;
        a_in_valid = 1'b0;
        step();
        a_idle("post_rst");

        // 1010_0100 MSB-first: 7,5,2
        a_send(8'hA4);
        a_beat("a4_0", 7, 1'b0, 3, 1'b0); step();
        a_beat("a4_1", 5, 1'b0, 3, 1'b0); step();
        a_beat("a4_2", 2, 1'b1, 3, 1'b0); step();
        a_idle("a4_end");

        // Zero word: one beat
        a_send(8'h00);
        a_beat("zero", 0, 1'b1, 0, 1'b1); step();
        a_idle("zero_end");

        // in_valid held across the last beat: taken only in the next IDLE cycle
        a_send(8'h08);
        a_in_valid = 1'b1;
        a_in_data  = 8'h03;
        a_beat("hold_08", 3, 1'b1, 1, 1'b0); step();
        a_idle("hold_idle");
        step();
        a_in_valid = 1'b0;
        a_beat("hold_03_0", 1, 1'b0, 2, 1'b0); step();
        a_beat("hold_03_1", 0, 1'b1, 2, 1'b0); step();
        a_idle("hold_end");

        // 0xFF under random backpressure with stray in_valid pulses
        a_send(8'hFF);
        idx = 7;
        cyc = 0;
        while (idx >= 0 && cyc < 200) begin
            a_out_ready = 1'($urandom_range(0, 1));
            a_in_valid  = 1'($urandom_range(0, 1));
            a_in_data   = 8'h0F;
            a_beat("ff", idx, 1'(idx == 0), 8, 1'b0);
            if (a_out_ready) idx--;
            step();
            cyc++;
        end
        check("ff all beats taken", 32'(idx), 32'hFFFF_FFFF);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        a_idle("ff_end");
        step();
        a_idle("ff_no_stray");

        // Reset after first beat of 0xF0
        a_send(8'hF0);
        a_beat("f0_0", 7, 1'b0, 4, 1'b0); step();
        a_beat("f0_1", 6, 1'b0, 4, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_idle("f0_rst");
        check("f0_rst out_pos", 32'(a_out_pos), 32'd0);
        step();
        a_idle("f0_rst2");
        a_send(8'h01);
        a_beat("one", 0, 1'b1, 1, 1'b0); step();
        a_idle("one_end");

        // Instance B: LSB-first 1010_0100 -> 2,5,7
        b_in_valid = 1'b1;
        b_in_data  = 8'hA4;
        step();
        b_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            $display("B beat %0d: pos=%0d last=%0d count=%0d", i, b_out_pos, b_out_last, b_out_count);
            check("b out_valid", 32'(b_out_valid), 32'd1);
            check("b out_pos",   32'(b_out_pos),   32'(b_exp[i]));
            check("b out_last",  32'(b_out_last),  32'(i == 2));
            check("b out_count", 32'(b_out_count), 32'd3);
            step();
        end
        check("b end out_valid", 32'(b_out_valid), 32'd0);
        check("b end in_ready",  32'(b_in_ready),  32'd1);

        // Instance C: 13-bit LSB-first 0x1001 -> 0,12
        c_in_valid = 1'b1;
        c_in_data  = 13'h1001;
        step();
        c_in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            $display("C beat %0d: pos=%0d last=%0d count=%0d", i, c_out_pos, c_out_last, c_out_count);
            check("c out_valid", 32'(c_out_valid), 32'd1);
            check("c out_pos",   32'(c_out_pos),   32'(c_exp[i]));
            check("c out_last",  32'(c_out_last),  32'(i == 1));
            check("c out_count", 32'(c_out_count), 32'd2);
            check("c out_zero",  32'(c_out_zero),  32'd0);
            step();
        end
        check("c end out_valid", 32'(c_out_valid), 32'd0);
        check("c end in_ready",  32'(c_in_ready),  32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
